// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the PE read master.
//   - Default widths/depths for the PE-side address, data word, request
//     queue and the outstanding-read window.
//   - Issue FSM state enum, also exported on the master's debug port.
//   - pe_byte_addr(): SDRAM byte address = base + PE offset, mod 2^32.
package pe_pkg;

    localparam int ADDR_W_DEF  = 17;
    localparam int DATA_W_DEF  = 16;
    localparam int QDEPTH_DEF  = 4;
    localparam int MAX_OUT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } issue_state_e;

    // The caller zero-extends the offset; the sum wraps naturally at 32 bits.
    function automatic logic [31:0] pe_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] offs);
        return base + offs;
    endfunction

endpackage

// File: rtl/pe_req_fifo.sv
// pe_req_fifo: synchronous request FIFO holding SDRAM byte addresses.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push          write request; push_data is the word to store
//   push_accept   push is taken this cycle (not full, or full with a pop)
//   pop           remove the head entry (ignored when empty)
//   head          current head entry (first-word fall-through)
//   full, empty   occupancy flags; count is the number of stored entries
module pe_req_fifo
    import pe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = QDEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       push_accept,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             pop_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full        = (cnt == CNT_W'(DEPTH));
    assign empty       = (cnt == '0);
    assign count       = cnt;
    assign head        = mem[rd_ptr];
    assign pop_ok      = pop && !empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign push_accept = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_accept) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)      rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push_accept, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pe_read_master.sv
// pe_read_master: turns PE read requests into Avalon-MM pipelined reads.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   master_en, addr_pe    PE request enable and PE-relative byte address
//   base_addr             SDRAM byte base added to every PE address
//   readdatavalid_pe      1-cycle pulse per returned word
//   readdata_pe           last returned word (held between pulses)
//   avm_*                 Avalon-MM read master (address/read/waitrequest,
//                         readdata/readdatavalid)
//   busy                  queue non-empty or reads in flight (registered)
//   overflow              sticky: a request was dropped on a full queue
//   state_dbg             current issue FSM state
//
// Handshake: a read is accepted on a cycle where avm_read=1 and
// avm_waitrequest=0; while waitrequest=1 the address and read stay frozen.
// Each accepted read is answered later by exactly one avm_readdatavalid
// cycle, in issue order; the PE side gets no backpressure.
module pe_read_master
    import pe_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int QDEPTH  = QDEPTH_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              master_en,
    input  logic [ADDR_W-1:0] addr_pe,
    input  logic [31:0]       base_addr,
    output logic              readdatavalid_pe,
    output logic [DATA_W-1:0] readdata_pe,
    output logic [31:0]       avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              overflow,
    output issue_state_e      state_dbg
);

    localparam int OUT_W  = $clog2(MAX_OUT + 1);
    localparam int QCNT_W = $clog2(QDEPTH + 1);

    issue_state_e      state_q, state_d;
    logic              en_q;
    logic [ADDR_W-1:0] last_addr;
    logic [OUT_W-1:0]  outstanding, out_next;
    logic [QCNT_W-1:0] q_count, entries_next;
    logic [31:0]       q_head, req_addr;
    logic              q_full, q_empty, q_push_acc;
    logic              new_req, accept, ret_ok, issuable;
    logic              rdv_q, busy_q, overflow_q;
    logic [DATA_W-1:0] rdata_q;

    // A request is a rising master_en or a change of the captured address.
    assign new_req  = master_en && (!en_q || (addr_pe != last_addr));
    assign req_addr = pe_byte_addr(base_addr, 32'(addr_pe));

    assign avm_read = (state_q != ST_IDLE);
    assign accept   = avm_read && !avm_waitrequest;
    // Returns with nothing in flight (e.g. after a reset) are discarded.
    assign ret_ok   = avm_readdatavalid && (outstanding != '0);

    pe_req_fifo #(
        .WIDTH (32),
        .DEPTH (QDEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (new_req),
        .push_data   (req_addr),
        .push_accept (q_push_acc),
        .pop         (accept),
        .head        (q_head),
        .full        (q_full),
        .empty       (q_empty),
        .count       (q_count)
    );

    // Look ahead to next-cycle occupancy so a request pushed at T can be
    // on the bus at T+1, and so back-to-back reads need no idle gap.
    assign out_next     = outstanding + OUT_W'(accept) - OUT_W'(ret_ok);
    assign entries_next = q_count + QCNT_W'(q_push_acc) - QCNT_W'(accept);
    assign issuable     = (entries_next != '0) && (out_next < OUT_W'(MAX_OUT));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (issuable) state_d = ST_ISSUE;
            end
            ST_ISSUE, ST_HOLD: begin
                if (avm_waitrequest) state_d = ST_HOLD;
                else                 state_d = issuable ? ST_ISSUE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            last_addr   <= '0;
            outstanding <= '0;
            rdv_q       <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= master_en;
            if (new_req) last_addr <= addr_pe;
            outstanding <= out_next;
            rdv_q       <= ret_ok;
            if (ret_ok) rdata_q <= avm_readdata;
            busy_q      <= !q_empty || (outstanding != '0);
            overflow_q  <= overflow_q || (new_req && !q_push_acc);
        end
    end

    // Head is only meaningful while a read is presented.
    assign avm_address      = avm_read ? q_head : 32'h0;
    assign readdatavalid_pe = rdv_q;
    assign readdata_pe      = rdata_q;
    assign busy             = busy_q;
    assign overflow         = overflow_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_pe_read_master.sv
module tb_pe_read_master;
  import pe_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         master_en;
  logic [16:0]  addr_pe;
  logic [31:0]  base_addr;
  logic         readdatavalid_pe;
  logic [15:0]  readdata_pe;
  logic [31:0]  avm_address;
  logic         avm_read;
  logic         avm_waitrequest;
  logic [15:0]  avm_readdata;
  logic         avm_readdatavalid;
  logic         busy;
  logic         overflow;
  issue_state_e state_dbg;

  pe_read_master dut (
    .clk               (clk),
    .rst               (rst),
    .master_en         (master_en),
    .addr_pe           (addr_pe),
    .base_addr         (base_addr),
    .readdatavalid_pe  (readdatavalid_pe),
    .readdata_pe       (readdata_pe),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .overflow          (overflow),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] issue_q[$];  // expected avm_address, in acceptance order
  logic [31:0] ret_q[$];    // accepted-to-be reads awaiting a return
  logic [15:0] exp_q[$];    // expected readdata_pe, in pulse order
  int acc_cnt   = 0;
  int pulse_cnt = 0;
  bit sb_on     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (avm_read && !avm_waitrequest) begin
        acc_cnt++;
        if (issue_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_accept: got read at 0x%0h, expected no read", avm_address);
        end else begin
          chk("accept_addr", avm_address, issue_q.pop_front());
        end
      end
      if (readdatavalid_pe) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_return: got pulse data 0x%0h, expected no pulse", readdata_pe);
        end else begin
          chk("return_data", {16'h0, readdata_pe}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    master_en = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    issue_q.delete();
    ret_q.delete();
    exp_q.delete();
  endtask

  task automatic request(input logic [16:0] a);
    logic [31:0] full_addr;
    full_addr = base_addr + {15'h0, a};
    master_en = 1'b1;
    addr_pe = a;
    issue_q.push_back(full_addr);
    ret_q.push_back(full_addr);
    tick();
  endtask

  task automatic give_return();
    logic [31:0] ra;
    logic [15:0] d;
    if (ret_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL return_model: got empty return model, expected a pending read");
    end else begin
      ra = ret_q.pop_front();
      d = ra[15:0] ^ 16'hC3C3;
      avm_readdata = d;
      avm_readdatavalid = 1'b1;
      exp_q.push_back(d);
      tick();
      avm_readdatavalid = 1'b0;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        en;
    logic [16:0] addr;
    logic        rv;
    logic [15:0] rd;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_pv;
    logic [15:0] e_pd;
  } vec_t;

  localparam int NV = 24;
  vec_t vt[NV];

  task automatic set_vec(input int i, input logic en, input logic [16:0] addr,
                         input logic rv, input logic [15:0] rd, input logic e_read,
                         input logic [31:0] e_addr, input logic e_pv, input logic [15:0] e_pd);
    vt[i] = '{en, addr, rv, rd, e_read, e_addr, e_pv, e_pd};
  endtask

  int a0, p0;

  initial begin
    // base 0x1000_0000: addresses 0,2,4 every 2 cycles, returns 1 cycle after acceptance
    set_vec(0,  1, 17'h0,  0, 16'h0,    0, 32'h0,         0, 16'h0);
    set_vec(1,  1, 17'h0,  0, 16'h0,    1, 32'h1000_0000, 0, 16'h0);
    set_vec(2,  1, 17'h2,  1, 16'h1111, 0, 32'h0,         0, 16'h0);
    set_vec(3,  1, 17'h2,  0, 16'h0,    1, 32'h1000_0002, 1, 16'h1111);
    set_vec(4,  1, 17'h4,  1, 16'h2222, 0, 32'h0,         0, 16'h1111);
    set_vec(5,  1, 17'h4,  0, 16'h0,    1, 32'h1000_0004, 1, 16'h2222);
    set_vec(6,  1, 17'h4,  1, 16'h3333, 0, 32'h0,         0, 16'h2222);
    set_vec(7,  0, 17'h4,  0, 16'h0,    0, 32'h0,         1, 16'h3333);
    set_vec(8,  0, 17'h4,  0, 16'h0,    0, 32'h0,         0, 16'h3333);
    // address 0x40 held 10 cycles -> one read; drop enable 1 cycle, re-enable -> second read
    set_vec(9,  1, 17'h40, 0, 16'h0,    0, 32'h0,         0, 16'h3333);
    set_vec(10, 1, 17'h40, 0, 16'h0,    1, 32'h1000_0040, 0, 16'h3333);
    set_vec(11, 1, 17'h40, 1, 16'h4444, 0, 32'h0,         0, 16'h3333);
    set_vec(12, 1, 17'h40, 0, 16'h0,    0, 32'h0,         1, 16'h4444);
    for (int i = 13; i <= 18; i++)
      set_vec(i, 1, 17'h40, 0, 16'h0,   0, 32'h0,         0, 16'h4444);
    set_vec(19, 0, 17'h40, 0, 16'h0,    0, 32'h0,         0, 16'h4444);
    set_vec(20, 1, 17'h40, 0, 16'h0,    0, 32'h0,         0, 16'h4444);
    set_vec(21, 1, 17'h40, 0, 16'h0,    1, 32'h1000_0040, 0, 16'h4444);
    set_vec(22, 1, 17'h40, 1, 16'h5555, 0, 32'h0,         0, 16'h4444);
    set_vec(23, 0, 17'h40, 0, 16'h0,    0, 32'h0,         1, 16'h5555);

    // ---- reset state ----
    rst = 1'b1;
    master_en = 1'b0;
    addr_pe = '0;
    base_addr = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_read",     {31'h0, avm_read}, 32'h0);
    chk("rst_address",  avm_address, 32'h0);
    chk("rst_pe_valid", {31'h0, readdatavalid_pe}, 32'h0);
    chk("rst_pe_data",  {16'h0, readdata_pe}, 32'h0);
    chk("rst_busy",     {31'h0, busy}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_state",    32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---- table: streaming requests and address-hold detection ----
    base_addr = 32'h1000_0000;
    for (int i = 0; i < NV; i++) begin
      master_en = vt[i].en;
      addr_pe = vt[i].addr;
      avm_readdatavalid = vt[i].rv;
      avm_readdata = vt[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d_read", i),     {31'h0, avm_read}, {31'h0, vt[i].e_read});
      chk($sformatf("vec%0d_address", i),  avm_address, vt[i].e_addr);
      chk($sformatf("vec%0d_pe_valid", i), {31'h0, readdatavalid_pe}, {31'h0, vt[i].e_pv});
      chk($sformatf("vec%0d_pe_data", i),  {16'h0, readdata_pe}, {16'h0, vt[i].e_pd});
      tick();
    end
    master_en = 1'b0;
    avm_readdatavalid = 1'b0;

    // ---- waitrequest stall on the first read ----
    do_reset();
    sb_on = 1'b1;
    base_addr = 32'h2000_0000;
    avm_waitrequest = 1'b1;
    a0 = acc_cnt;
    request(17'h10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_read",    {31'h0, avm_read}, 32'h1);
      chk("stall_address", avm_address, 32'h2000_0010);
      chk("stall_state",   32'(state_dbg), (k == 0) ? 32'(ST_ISSUE) : 32'(ST_HOLD));
      tick();
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("stall_release_read", {31'h0, avm_read}, 32'h1);
    tick();
    @(negedge clk);
    chk("stall_after_read", {31'h0, avm_read}, 32'h0);
    chk("stall_accepts", 32'(acc_cnt - a0), 32'd1);
    master_en = 1'b0;
    give_return();
    tick();

    // ---- six requests, returns withheld: 4 in flight, 2 queued, then drain ----
    do_reset();
    base_addr = 32'h3000_0000;
    a0 = acc_cnt;
    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) request(17'(32'h100 + 2 * i));
    master_en = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("window_accepts", 32'(acc_cnt - a0), 32'd4);
    chk("window_read",    {31'h0, avm_read}, 32'h0);
    chk("window_busy",    {31'h0, busy}, 32'h1);
    chk("window_state",   32'(state_dbg), 32'(ST_IDLE));
    tick();
    for (int i = 0; i < 5; i++) begin
      give_return();
      tick();
      tick();
    end
    give_return();
    @(negedge clk);
    chk("drain_last_pulse", {31'h0, readdatavalid_pe}, 32'h1);
    chk("drain_busy_at_pulse", {31'h0, busy}, 32'h1);
    tick();
    @(negedge clk);
    chk("drain_busy_after", {31'h0, busy}, 32'h0);
    chk("drain_pulses",  32'(pulse_cnt - p0), 32'd6);
    chk("drain_accepts", 32'(acc_cnt - a0), 32'd6);
    chk("drain_exp_left", 32'(exp_q.size()), 32'd0);
    tick();

    // ---- full queue with MAX_OUT in flight: ninth request dropped ----
    do_reset();
    base_addr = 32'h4000_0000;
    a0 = acc_cnt;
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) request(17'(32'h200 + 4 * i));
    master_en = 1'b1;
    addr_pe = 17'h240;
    @(negedge clk);
    chk("ovf_before", {31'h0, overflow}, 32'h0);
    tick();
    master_en = 1'b0;
    @(negedge clk);
    chk("ovf_set",   {31'h0, overflow}, 32'h1);
    chk("ovf_read",  {31'h0, avm_read}, 32'h0);
    chk("ovf_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    for (int i = 0; i < 8; i++) begin
      give_return();
      tick();
      tick();
    end
    tick();
    @(negedge clk);
    chk("ovf_sticky",   {31'h0, overflow}, 32'h1);
    chk("ovf_busy",     {31'h0, busy}, 32'h0);
    chk("ovf_pulses",   32'(pulse_cnt - p0), 32'd8);
    chk("ovf_accepts",  32'(acc_cnt - a0), 32'd8);
    tick();
    do_reset();
    @(negedge clk);
    chk("ovf_cleared", {31'h0, overflow}, 32'h0);
    tick();

    // ---- reset with two reads in flight, then stray returns ----
    base_addr = 32'h5000_0000;
    a0 = acc_cnt;
    request(17'h20);
    request(17'h22);
    master_en = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("stray_inflight", 32'(acc_cnt - a0), 32'd2);
    chk("stray_busy_pre", {31'h0, busy}, 32'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue_q.delete();
    ret_q.delete();
    exp_q.delete();
    p0 = pulse_cnt;
    for (int k = 0; k < 2; k++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = 16'hBEEF;
      @(negedge clk);
      chk("stray_pe_valid", {31'h0, readdatavalid_pe}, 32'h0);
      chk("stray_busy", {31'h0, busy}, 32'h0);
      tick();
    end
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    chk("stray_pe_valid_last", {31'h0, readdatavalid_pe}, 32'h0);
    chk("stray_pe_data", {16'h0, readdata_pe}, 32'h0);
    chk("stray_pulses", 32'(pulse_cnt - p0), 32'd0);
    tick();
    // a fresh read still completes normally with the count back at zero
    request(17'h30);
    master_en = 1'b0;
    tick();
    give_return();
    @(negedge clk);
    chk("post_stray_pulse", {31'h0, readdatavalid_pe}, 32'h1);
    tick();
    tick();
    @(negedge clk);
    chk("post_stray_busy", {31'h0, busy}, 32'h0);
    sb_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
